// File: rtl/core_mem_arb_pkg.sv
// core_mem_arb_pkg
// Shared definitions for the core memory arbiter: bus widths, arbiter
// state encoding, pipeline hold codes and the default abort limit.
// No ports; imported by core_mem_arb and arb_timeout.
package core_mem_arb_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INSN_W = 32;
  localparam int STRB_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [CNT_W-1:0] DEFAULT_TIMEOUT = 8'd255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    EX_BUSY = 2'd2
  } arb_state_t;

  localparam logic [2:0] HOLD_CODE_NOPE = 3'd0;
  localparam logic [2:0] HOLD_CODE_PC   = 3'd1;
  localparam logic [2:0] HOLD_CODE_IF   = 3'd2;
  localparam logic [2:0] HOLD_CODE_ID   = 3'd3;
  localparam logic [2:0] HOLD_CODE_EX   = 3'd4;

endpackage

// File: rtl/arb_timeout.sv
// arb_timeout
// Wait counter for an outstanding bus transaction.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (asserted on a new grant)
//   en         : count this cycle (busy and no ack)
//   expired    : this counting cycle brings the count to TIMEOUT
module arb_timeout
  import core_mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Flag the cycle whose increment reaches TIMEOUT, so the request is
  // held for exactly TIMEOUT cycles without an ack before the abort.
  assign expired = en && (count == (TIMEOUT - 1'b1));

endmodule

// File: rtl/core_mem_arb.sv
// core_mem_arb
// Arbitrates a single memory bus between the instruction fetch (IF) and
// execute (EX) stages. EX has fixed priority, grants are never preempted,
// and every transaction completes on bus_ack or aborts after TIMEOUT cycles.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req/if_addr             : fetch request (level) and address
//   if_valid/if_rdata          : one-cycle fetch completion and instruction
//   ex_rd_en/ex_wr_en          : EX load / store requests (level)
//   ex_addr_rd/ex_addr_wr      : load / store addresses
//   ex_wdata/ex_wstrb          : store data and byte enables
//   ex_valid/ex_rdata          : one-cycle EX completion and load data
//   bus_req/bus_we/bus_addr/
//   bus_wdata/bus_wstrb        : registered memory request
//   bus_ack/bus_rdata          : memory completion pulse and read data
//   hold_code                  : combinational pipeline hold code
//   err_o                      : one-cycle pulse on timeout or rd/wr conflict
module core_mem_arb
  import core_mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [INSN_W-1:0] if_rdata,
  input  logic              ex_rd_en,
  input  logic              ex_wr_en,
  input  logic [ADDR_W-1:0] ex_addr_rd,
  input  logic [ADDR_W-1:0] ex_addr_wr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [STRB_W-1:0] ex_wstrb,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [2:0]        hold_code,
  output logic              err_o
);

  arb_state_t state, state_next;

  logic if_done;
  logic ex_done;
  logic if_eff;
  logic ex_eff;
  logic busy;
  logic grant_if;
  logic grant_ex;
  logic finish;
  logic abort;
  logic expired;

  // A requester just served keeps its level request up during its valid
  // cycle; the done flag hides it for that one cycle so it is not reissued.
  assign if_eff = if_req & ~if_done;
  assign ex_eff = (ex_rd_en | ex_wr_en) & ~ex_done;
  assign busy   = (state != IDLE);

  arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (grant_if | grant_ex),
    .en      (busy & ~bus_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_ex   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    hold_code  = HOLD_CODE_NOPE;

    case (state)
      IDLE: begin
        if (ex_eff) begin
          grant_ex   = 1'b1;
          state_next = EX_BUSY;
        end else if (if_eff) begin
          grant_if   = 1'b1;
          state_next = IF_BUSY;
        end
      end
      IF_BUSY, EX_BUSY: begin
        // An ack arriving in the expiry cycle still completes normally.
        if (bus_ack) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (ex_eff || state == EX_BUSY) begin
      hold_code = HOLD_CODE_EX;
    end else if (if_eff || state == IF_BUSY) begin
      hold_code = HOLD_CODE_IF;
    end
  end

  // Bus request registers, completion pulses and captured read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      if_valid  <= 1'b0;
      ex_valid  <= 1'b0;
      if_rdata  <= '0;
      ex_rdata  <= '0;
      err_o     <= 1'b0;
      if_done   <= 1'b0;
      ex_done   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      ex_valid <= 1'b0;
      err_o    <= 1'b0;
      if_done  <= 1'b0;
      ex_done  <= 1'b0;

      if (grant_ex) begin
        // A simultaneous load and store performs only the store.
        bus_req <= 1'b1;
        bus_we  <= ex_wr_en;
        err_o   <= ex_wr_en & ex_rd_en;
        if (ex_wr_en) begin
          bus_addr  <= ex_addr_wr;
          bus_wdata <= ex_wdata;
          bus_wstrb <= ex_wstrb;
        end else begin
          bus_addr  <= ex_addr_rd;
          bus_wdata <= '0;
          bus_wstrb <= '0;
        end
      end else if (grant_if) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b0;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        bus_wstrb <= '0;
      end else if (finish || abort) begin
        bus_req <= 1'b0;
        err_o   <= abort;
        if (state == IF_BUSY) begin
          if_valid <= 1'b1;
          if_done  <= 1'b1;
          if_rdata <= abort ? '0 : bus_rdata[INSN_W-1:0];
        end else begin
          ex_valid <= 1'b1;
          ex_done  <= 1'b1;
          if (abort) begin
            ex_rdata <= '0;
          end else if (!bus_we) begin
            ex_rdata <= bus_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arb.sv
// tb_core_mem_arb
// Directed, self-checking bench for core_mem_arb. Inputs change 1 time
// unit after each rising edge; outputs are sampled at that point too.
module tb_core_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        ex_rd_en;
  logic        ex_wr_en;
  logic [63:0] ex_addr_rd;
  logic [63:0] ex_addr_wr;
  logic [63:0] ex_wdata;
  logic [7:0]  ex_wstrb;
  logic        ex_valid;
  logic [63:0] ex_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic [2:0]  hold_code;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_mem_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_valid   (if_valid),
    .if_rdata   (if_rdata),
    .ex_rd_en   (ex_rd_en),
    .ex_wr_en   (ex_wr_en),
    .ex_addr_rd (ex_addr_rd),
    .ex_addr_wr (ex_addr_wr),
    .ex_wdata   (ex_wdata),
    .ex_wstrb   (ex_wstrb),
    .ex_valid   (ex_valid),
    .ex_rdata   (ex_rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .hold_code  (hold_code),
    .err_o      (err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b1;
    if_req     = 1'b0;
    if_addr    = '0;
    ex_rd_en   = 1'b0;
    ex_wr_en   = 1'b0;
    ex_addr_rd = '0;
    ex_addr_wr = '0;
    ex_wdata   = '0;
    ex_wstrb   = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_req, bus_we, bus_wstrb, if_valid, ex_valid, err_o} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %h expected 0",
               {bus_req, bus_we, bus_wstrb, if_valid, ex_valid, err_o});
    end
    checks++;
    if ({bus_addr, bus_wdata, if_rdata, ex_rdata} !== 224'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h if_rdata=%h ex_rdata=%h expected all 0",
               bus_addr, bus_wdata, if_rdata, ex_rdata);
    end
    checks++;
    if (hold_code !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %0d expected 0", hold_code);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    // cycle N
    if_req  = 1'b1;
    if_addr = 64'h8000_0000;
    #1;
    checks++;
    if (hold_code !== 3'd2) begin
      errors++;
      $display("[TB] FAIL fetch_hold_req: got %0d expected 2", hold_code);
    end
    step(); // N+1
    checks++;
    if ({bus_req, bus_we, bus_wstrb} !== {1'b1, 1'b0, 8'h00} || bus_addr !== 64'h8000_0000) begin
      errors++;
      $display("[TB] FAIL fetch_issue: got req=%b we=%b strb=%h addr=%h expected 1 0 00 80000000",
               bus_req, bus_we, bus_wstrb, bus_addr);
    end
    bus_ack   = 1'b1;
    bus_rdata = 64'hFFFF_FFFF_0000_0013;
    step(); // N+2
    bus_ack = 1'b0;
    checks++;
    if ({if_valid, bus_req, ex_valid} !== 3'b100 || if_rdata !== 32'h0000_0013) begin
      errors++;
      $display("[TB] FAIL fetch_valid: got valid=%b req=%b ex_valid=%b rdata=%h expected 1 0 0 00000013",
               if_valid, bus_req, ex_valid, if_rdata);
    end
    step(); // N+3: if_req was still high at the last edge
    if_req = 1'b0;
    checks++;
    if ({bus_req, if_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL fetch_no_reissue: got req=%b valid=%b expected 0 0", bus_req, if_valid);
    end
  endtask

  task automatic test_priority();
    if_req     = 1'b1;
    if_addr    = 64'h8000_0004;
    ex_rd_en   = 1'b1;
    ex_addr_rd = 64'h1000;
    #1;
    checks++;
    if (hold_code !== 3'd4) begin
      errors++;
      $display("[TB] FAIL prio_hold_req: got %0d expected 4", hold_code);
    end
    step(); // N+1
    checks++;
    if ({bus_req, bus_we, err_o} !== 3'b100 || bus_addr !== 64'h1000 || hold_code !== 3'd4) begin
      errors++;
      $display("[TB] FAIL prio_ex_first: got req=%b we=%b err=%b addr=%h hold=%0d expected 1 0 0 1000 4",
               bus_req, bus_we, err_o, bus_addr, hold_code);
    end
    step(); // N+2, no ack yet
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 64'h1000 || hold_code !== 3'd4) begin
      errors++;
      $display("[TB] FAIL prio_wait: got req=%b addr=%h hold=%0d expected 1 1000 4",
               bus_req, bus_addr, hold_code);
    end
    step(); // N+3
    bus_ack   = 1'b1;
    bus_rdata = 64'h1122_3344_5566_7788;
    #1;
    checks++;
    if (hold_code !== 3'd4) begin
      errors++;
      $display("[TB] FAIL prio_hold_ack: got %0d expected 4", hold_code);
    end
    step(); // N+4
    bus_ack = 1'b0;
    checks++;
    if ({ex_valid, bus_req} !== 2'b10 || ex_rdata !== 64'h1122_3344_5566_7788 || hold_code !== 3'd2) begin
      errors++;
      $display("[TB] FAIL prio_ex_valid: got valid=%b req=%b rdata=%h hold=%0d expected 1 0 1122334455667788 2",
               ex_valid, bus_req, ex_rdata, hold_code);
    end
    step(); // N+5
    ex_rd_en = 1'b0;
    checks++;
    if ({bus_req, bus_we, ex_valid} !== 3'b100 || bus_addr !== 64'h8000_0004) begin
      errors++;
      $display("[TB] FAIL prio_if_next: got req=%b we=%b ex_valid=%b addr=%h expected 1 0 0 80000004",
               bus_req, bus_we, ex_valid, bus_addr);
    end
    bus_ack   = 1'b1;
    bus_rdata = 64'hFFFF_FFFF_0010_0093;
    step(); // N+6
    bus_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h0010_0093) begin
      errors++;
      $display("[TB] FAIL prio_if_valid: got valid=%b rdata=%h expected 1 00100093", if_valid, if_rdata);
    end
    step();
    if_req = 1'b0;
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_idle: got req=%b expected 0", bus_req);
    end
  endtask

  task automatic test_store_during_fetch();
    if_req  = 1'b1;
    if_addr = 64'h8000_0008;
    step(); // N+1, fetch in flight
    ex_wr_en   = 1'b1;
    ex_addr_wr = 64'h2000;
    ex_wdata   = 64'h0000_0000_DEAD_BEEF;
    ex_wstrb   = 8'h0F;
    #1;
    checks++;
    if ({bus_req, bus_we} !== 2'b10 || hold_code !== 3'd4 || bus_addr !== 64'h8000_0008) begin
      errors++;
      $display("[TB] FAIL store_wait_issue: got req=%b we=%b addr=%h hold=%0d expected 1 0 80000008 4",
               bus_req, bus_we, bus_addr, hold_code);
    end
    step(); // N+2
    checks++;
    if (bus_we !== 1'b0 || bus_addr !== 64'h8000_0008 || hold_code !== 3'd4) begin
      errors++;
      $display("[TB] FAIL store_no_preempt: got we=%b addr=%h hold=%0d expected 0 80000008 4",
               bus_we, bus_addr, hold_code);
    end
    bus_ack   = 1'b1;
    bus_rdata = 64'h0000_0000_0000_0073;
    step(); // N+3: fetch valid cycle, EX granted here
    bus_ack = 1'b0;
    checks++;
    if ({if_valid, bus_req} !== 2'b10 || if_rdata !== 32'h0000_0073 || hold_code !== 3'd4) begin
      errors++;
      $display("[TB] FAIL store_fetch_done: got valid=%b req=%b rdata=%h hold=%0d expected 1 0 00000073 4",
               if_valid, bus_req, if_rdata, hold_code);
    end
    step(); // N+4
    if_req = 1'b0;
    checks++;
    if ({bus_req, bus_we, err_o} !== 3'b110 || bus_addr !== 64'h2000 ||
        bus_wdata !== 64'h0000_0000_DEAD_BEEF || bus_wstrb !== 8'h0F || hold_code !== 3'd4) begin
      errors++;
      $display("[TB] FAIL store_write: got req=%b we=%b err=%b addr=%h wdata=%h strb=%h hold=%0d expected 1 1 0 2000 deadbeef 0f 4",
               bus_req, bus_we, err_o, bus_addr, bus_wdata, bus_wstrb, hold_code);
    end
    bus_ack = 1'b1;
    step(); // N+5
    bus_ack  = 1'b0;
    ex_wr_en = 1'b0;
    #1;
    checks++;
    if ({ex_valid, bus_req, err_o} !== 3'b100 || hold_code !== 3'd0) begin
      errors++;
      $display("[TB] FAIL store_done: got valid=%b req=%b err=%b hold=%0d expected 1 0 0 0",
               ex_valid, bus_req, err_o, hold_code);
    end
    step();
  endtask

  task automatic test_timeout();
    int  high = 0;
    bit  dropped = 1'b0;
    ex_rd_en   = 1'b1;
    ex_addr_rd = 64'h3000;
    step(); // first busy cycle
    for (int i = 0; i < 300 && !dropped; i++) begin
      if (bus_req === 1'b1) begin
        high++;
        step();
      end else begin
        dropped = 1'b1;
      end
    end
    checks++;
    if (!dropped) begin
      errors++;
      $display("[TB] FAIL timeout_bound: bus_req still high after %0d cycles, expected drop after 255", high);
    end
    checks++;
    if (high != 255) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d cycles of bus_req expected 255", high);
    end
    checks++;
    if ({ex_valid, err_o} !== 2'b11 || ex_rdata !== 64'h0) begin
      errors++;
      $display("[TB] FAIL timeout_abort: got valid=%b err=%b rdata=%h expected 1 1 0",
               ex_valid, err_o, ex_rdata);
    end
    ex_rd_en = 1'b0;
    step();
    checks++;
    if ({bus_req, ex_valid, err_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL timeout_after: got req=%b valid=%b err=%b expected 0 0 0",
               bus_req, ex_valid, err_o);
    end
  endtask

  task automatic test_conflict();
    ex_rd_en   = 1'b1;
    ex_wr_en   = 1'b1;
    ex_addr_rd = 64'h4000;
    ex_addr_wr = 64'h5000;
    ex_wdata   = 64'h0123_4567_89AB_CDEF;
    ex_wstrb   = 8'hFF;
    step(); // grant cycle
    checks++;
    if ({bus_req, bus_we, err_o} !== 3'b111 || bus_addr !== 64'h5000 ||
        bus_wdata !== 64'h0123_4567_89AB_CDEF || bus_wstrb !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL conflict_write: got req=%b we=%b err=%b addr=%h wdata=%h strb=%h expected 1 1 1 5000 0123456789abcdef ff",
               bus_req, bus_we, err_o, bus_addr, bus_wdata, bus_wstrb);
    end
    bus_ack = 1'b1;
    step();
    bus_ack  = 1'b0;
    checks++;
    if ({ex_valid, err_o, bus_req} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL conflict_done: got valid=%b err=%b req=%b expected 1 0 0",
               ex_valid, err_o, bus_req);
    end
    step(); // both enables still high at the last edge
    ex_rd_en = 1'b0;
    ex_wr_en = 1'b0;
    checks++;
    if ({bus_req, err_o, ex_valid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL conflict_single: got req=%b err=%b valid=%b expected 0 0 0",
               bus_req, err_o, ex_valid);
    end
  endtask

  task automatic test_reset_busy();
    ex_rd_en   = 1'b1;
    ex_addr_rd = 64'h6000;
    step();
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstbusy_issue: got req=%b expected 1", bus_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, bus_addr} !== 65'h0) begin
      errors++;
      $display("[TB] FAIL rstbusy_async: got req=%b addr=%h expected 0 0", bus_req, bus_addr);
    end
    ex_rd_en  = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 64'hAAAA_5555_AAAA_5555;
    step();
    bus_ack = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({ex_valid, bus_req, err_o} !== 3'b000 || ex_rdata !== 64'h0 || hold_code !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rstbusy_no_valid: got valid=%b req=%b err=%b rdata=%h hold=%0d expected 0 0 0 0 0",
               ex_valid, bus_req, err_o, ex_rdata, hold_code);
    end
  endtask

  task automatic test_idle_ack();
    bus_ack   = 1'b1;
    bus_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    bus_ack = 1'b0;
    checks++;
    if ({if_valid, ex_valid, bus_req, err_o} !== 4'b0000 || if_rdata !== 32'h0 || ex_rdata !== 64'h0) begin
      errors++;
      $display("[TB] FAIL idle_ack: got ifv=%b exv=%b req=%b err=%b if_rdata=%h ex_rdata=%h expected all 0",
               if_valid, ex_valid, bus_req, err_o, if_rdata, ex_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store_during_fetch();
    test_timeout();
    test_conflict();
    test_reset_busy();
    test_idle_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
